// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame (data width, parity, stop bits) and an
// internal byte FIFO; frames leave back-to-back while data is queued.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DIV_W-1:0]                 baud_div,
    input  logic                             parity_en,
    input  logic                             parity_odd,
    input  logic                             two_stop,
    input  logic                             wr_en,
    input  logic [DATA_BITS-1:0]             wr_data,
    output logic                             full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             overflow,
    output logic                             busy,
    output logic                             TxD
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        rd_ptr, wr_ptr;
    logic [DATA_BITS-1:0] shreg;
    logic [DIV_W-1:0]     cnt, div_l;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx, par_en_l, two_stop_l, par_bit;
    logic                 empty, wr_ok, pop, tick, txd_n;

    // Divisors below 2 are stretched to a two-cycle bit.
    function automatic logic [DIV_W-1:0] reload(input logic [DIV_W-1:0] div);
        return (div < DIV_W'(2)) ? DIV_W'(1) : div - DIV_W'(1);
    endfunction

    function automatic logic frame_parity(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    assign empty = (fifo_count == '0);
    assign full  = (fifo_count == CW'(FIFO_DEPTH));
    assign wr_ok = wr_en && !full;
    assign tick  = (cnt == '0);

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START:  if (tick) state_n = DATA;
            DATA:   if (tick && bit_idx == BW'(DATA_BITS - 1)) state_n = par_en_l ? PARITY : STOP;
            PARITY: if (tick) state_n = STOP;
            STOP: begin
                // The last stop tick chains straight into the next queued frame.
                if (tick && (stop_idx || !two_stop_l)) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        txd_n = 1'b1;
        case (state)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shreg[0];
            PARITY:  txd_n = par_bit;
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            TxD        <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            div_l      <= '0;
            par_en_l   <= 1'b0;
            two_stop_l <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_n;
            TxD   <= txd_n;
            if (pop)
                cnt <= reload(baud_div);
            else if (state != IDLE)
                cnt <= tick ? reload(div_l) : cnt - DIV_W'(1);
            if (state == START)
                bit_idx <= '0;
            else if (state == DATA && tick)
                bit_idx <= bit_idx + BW'(1);
            if (state != STOP)
                stop_idx <= 1'b0;
            else if (tick)
                stop_idx <= 1'b1;
            if (pop) begin
                div_l      <= baud_div;
                par_en_l   <= parity_en;
                two_stop_l <= two_stop;
            end
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
        if (pop) begin
            shreg   <= mem[rd_ptr];
            par_bit <= frame_parity(mem[rd_ptr], parity_odd);
        end else if (state == DATA && tick) begin
            shreg <= shreg >> 1;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames, a serial
// monitor decodes TxD cycle by cycle and compares every bit and its duration.
module tb_uart_tx_fifo;
    logic        clk;
    logic        reset;
    logic [15:0] baud_div;
    logic        parity_en, parity_odd, two_stop;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic [2:0]  fifo_count;
    logic        overflow, busy, TxD;

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clk(clk), .reset(reset), .baud_div(baud_div), .parity_en(parity_en),
        .parity_odd(parity_odd), .two_stop(two_stop), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .fifo_count(fifo_count), .overflow(overflow), .busy(busy), .TxD(TxD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         period;
        bit         par_en;
        bit         par_odd;
        bit         two_stop;
        bit         b2b;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input int per, input bit pe, input bit po,
                            input bit ts, input bit b2b);
        frame_t f;
        f.data = d; f.period = per; f.par_en = pe; f.par_odd = po; f.two_stop = ts; f.b2b = b2b;
        exp_q.push_back(f);
    endtask

    task automatic set_cfg(input logic [15:0] div, input bit pe, input bit po, input bit ts);
        baud_div = div; parity_en = pe; parity_odd = po; two_stop = ts;
    endtask

    // Single write into an idle, empty block: checks pop/start latency and busy length.
    task automatic send_one(input logic [7:0] d, input int exp_busy);
        int bcnt;
        wr_data = d; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        chk($sformatf("count_after_write_%02h", d), fifo_count, 1);
        step();
        chk($sformatf("busy_at_pop_%02h", d), busy, 1);
        chk($sformatf("txd_high_at_pop_%02h", d), TxD, 1);
        chk($sformatf("count_after_pop_%02h", d), fifo_count, 0);
        step();
        chk($sformatf("start_latency_%02h", d), TxD, 0);
        bcnt = 2;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!busy) break;
            bcnt++;
        end
        chk($sformatf("busy_cycles_%02h", d), bcnt, exp_busy);
        step();
        step();
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            step();
            n++;
        end
        chk({name, "_idle_reached"}, busy, 0);
        step();
        step();
    endtask

    // Serial monitor: decodes frames off TxD and checks them against the queue.
    initial begin : monitor
        frame_t f;
        logic   bits [0:15];
        int     nbits, gap;
        logic   seen;
        bit     abort;
        gap = 1000;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                exp_q.delete();
                gap = 1000;
            end else if (TxD === 1'b1) begin
                gap++;
            end else if (TxD === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("start_bit_with_no_frame_expected", exp_q.size(), 1);
                    for (int w = 0; w < 2000 && TxD !== 1'b1 && reset !== 1'b1; w++)
                        @(negedge clk);
                    gap = 0;
                end else begin
                    f = exp_q.pop_front();
                    if (f.b2b) chk($sformatf("idle_gap_before_%02h", f.data), gap, 0);
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[1 + i] = f.data[i];
                    nbits = 9;
                    if (f.par_en) begin
                        bits[nbits] = (^f.data) ^ f.par_odd;
                        nbits++;
                    end
                    bits[nbits] = 1'b1;
                    nbits++;
                    if (f.two_stop) begin
                        bits[nbits] = 1'b1;
                        nbits++;
                    end
                    abort = 1'b0;
                    for (int b = 0; b < nbits; b++) begin
                        seen = bits[b];
                        for (int c = 0; c < f.period; c++) begin
                            if (b != 0 || c != 0) begin
                                @(negedge clk);
                                if (reset === 1'b1) abort = 1'b1;
                            end
                            if (abort) break;
                            if (TxD !== bits[b]) seen = TxD;
                        end
                        if (abort) break;
                        chk($sformatf("frame_%02h_bit%0d", f.data, b), seen, bits[b]);
                    end
                    if (abort) begin
                        exp_q.delete();
                        gap = 1000;
                    end else begin
                        gap = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int bad;
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        set_cfg(16'd4, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("reset_txd", TxD, 1);
        chk("reset_busy", busy, 0);
        chk("reset_full", full, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_overflow", overflow, 0);
        reset = 1'b0;

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (TxD !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) bad++;
        end
        chk("idle_bad_cycles", bad, 0);

        // 8N1 at 4 cycles/bit: 10 bits x 4 = 40 busy cycles.
        set_cfg(16'd4, 1'b0, 1'b0, 1'b0);
        push_exp(8'h55, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        send_one(8'h55, 40);

        // 8 data + odd parity + 2 stop: 12 bits x 4 = 48 cycles.
        set_cfg(16'd4, 1'b1, 1'b1, 1'b1);
        push_exp(8'h03, 4, 1'b1, 1'b1, 1'b1, 1'b0);
        send_one(8'h03, 48);

        // Divisor 1 behaves as 2: 10 bits x 2 = 20 cycles.
        set_cfg(16'd1, 1'b0, 1'b0, 1'b0);
        push_exp(8'hA5, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        send_one(8'hA5, 20);

        // Divisor change mid-frame only affects the next popped frame.
        set_cfg(16'd4, 1'b0, 1'b0, 1'b0);
        push_exp(8'h5A, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        wr_data = 8'h5A; wr_en = 1'b1;
        step();
        wr_data = 8'h3C;
        step();
        wr_en = 1'b0;
        step(); step(); step();
        baud_div = 16'd8;
        wait_idle("div_change", 400);

        // Fill during a frame: four accepted, fifth dropped and flagged.
        set_cfg(16'd4, 1'b0, 1'b0, 1'b0);
        push_exp(8'h0F, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push_exp(8'h10 + 8'(i), 4, 1'b0, 1'b0, 1'b0, 1'b1);
        wr_data = 8'h0F; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        step(); step();
        chk("count_before_fill", fifo_count, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("overflow_before_drop", overflow, 0);
            wr_data = 8'h10 + 8'(i); wr_en = 1'b1;
            step();
            chk($sformatf("fill_count_%0d", i), fifo_count, (i < 4) ? i + 1 : 4);
            chk($sformatf("fill_full_%0d", i), full, (i >= 3) ? 1 : 0);
        end
        wr_en = 1'b0;
        chk("overflow_after_drop", overflow, 1);
        wait_idle("fill", 600);
        chk("overflow_sticky", overflow, 1);
        chk("count_after_drain", fifo_count, 0);
        chk("frames_all_seen", exp_q.size(), 0);

        // Reset mid-DATA with three bytes queued.
        push_exp(8'h11, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(8'h22, 4, 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp(8'h33, 4, 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp(8'h44, 4, 1'b0, 1'b0, 1'b0, 1'b1);
        wr_data = 8'h11; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'h22 + 8'(8'h11 * i); wr_en = 1'b1;
            step();
        end
        wr_en = 1'b0;
        chk("queued_before_reset", fifo_count, 3);
        for (int i = 0; i < 8; i++) step();
        reset = 1'b1;
        step();
        chk("abort_txd", TxD, 1);
        chk("abort_count", fifo_count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_overflow", overflow, 0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (TxD !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
        end
        chk("post_abort_bad_cycles", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. Frame format is configurable: data width, optional even/odd parity, one or two stop bits. The baud divisor is a run-time input. Bytes are queued in an internal FIFO, so frames go out back-to-back with no host handshake per byte. It sits between any byte producer (the I2C temperature path or the button logic) and the board TxD pin.

Parameters:
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first
FIFO_DEPTH, 4, FIFO entries, power of two, 2..64
DIV_W, 16, width of the baud divisor input

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
baud_div  input  DIV_W  clock cycles per bit period; values 0 and 1 are treated as 2
parity_en  input  1  1 = insert a parity bit after the data bits
parity_odd  input  1  0 = even parity, 1 = odd parity (used only when parity_en=1)
two_stop  input  1  0 = one stop bit, 1 = two stop bits
wr_en  input  1  push wr_data into the FIFO this cycle
wr_data  input  DATA_BITS  byte to transmit
full  output  1  FIFO holds FIFO_DEPTH entries
fifo_count  output  $clog2(FIFO_DEPTH+1)  entries currently queued
overflow  output  1  sticky: a write was attempted while full
busy  output  1  a frame is in progress (state != IDLE)
TxD  output  1  serial line, idles high

Behaviour:
- Reset values (one cycle after reset is sampled high): TxD=1, busy=0, full=0, fifo_count=0, overflow=0, FSM=IDLE, FIFO pointers=0.
- Reset mid-frame aborts the frame: TxD=1 on the next edge and FIFO contents are discarded.
- FIFO:
  - Synchronous circular buffer with wrapping read/write pointers.
  - A write is accepted when wr_en=1 and full=0, evaluated on registered state. A write while full is dropped even if a pop occurs in the same cycle, and it sets overflow. overflow clears only on reset.
  - A simultaneous accepted write and pop leaves fifo_count unchanged.
- Configuration latch: baud_div, parity_en, parity_odd and two_stop are captured when a frame is popped. Changes mid-frame do not affect the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty, pop the head into the shift register, latch the config, go to START.
  - START: TxD=0 for one bit period.
  - DATA: DATA_BITS bit periods, LSB first.
  - PARITY (only if parity_en): TxD = XOR of the data bits XOR parity_odd, for one bit period.
  - STOP: TxD=1 for one or two bit periods.
- Bit period: a down-counter loaded with (baud_div−1) at each bit boundary. The bit ends when the counter reaches 0 and a tick fires. Each bit lasts exactly max(baud_div,2) cycles.
- Frame length: (1 + DATA_BITS + parity_en + 1 + two_stop) × period cycles.
- Latency: a write at edge N into an idle, empty block gives a pop at edge N+1 and TxD=0 from edge N+2.
- Back-to-back frames: on the final tick of the last stop bit, if the FIFO is non-empty, the next head is popped in the same cycle and the next START begins immediately. There is zero idle gap. Otherwise the FSM returns to IDLE with TxD=1.
- busy=1 in every state except IDLE.
- TxD is registered; there are no combinational paths from inputs to TxD.

Test Plan:
- Reset, then idle 20 cycles -> TxD=1, busy=0, fifo_count=0, overflow=0 throughout.
- baud_div=4, 8N1, write 0x55 -> TxD=0 from write+2. Bits 1,0,1,0,1,0,1,0 then stop 1, each bit 4 cycles. busy high 40 cycles.
- baud_div=4, parity_en=1, parity_odd=1, two_stop=1, write 0x03 -> data 1,1,0,0,0,0,0,0, parity bit 1, two stop bits. Frame is 48 cycles.
- baud_div=1 -> each bit lasts 2 cycles. baud_div changed mid-frame from 4 to 8 -> current frame keeps 4 cycles/bit, the next frame uses 8.
- During a frame, write 0x10..0x14 on 5 consecutive cycles -> first four accepted. full=1 after the 4th, 0x14 dropped, overflow=1. 0x10..0x13 are then sent back-to-back with no idle cycle between the stop bit and the next start bit.
- Assert reset mid-DATA with 3 entries queued -> TxD=1 next cycle, fifo_count=0, busy=0, and no further frames are sent.
